cv32e41s_obi_ram_bridge: RTL and testbench

OBI initiator-facing bridge that drives a single port of the cv32e41s word-wide on-chip RAM. It accepts core OBI transactions, converts them to RAM enable/write/address/data strobes and returns OBI responses. The RAM port has no byte enables, so the bridge performs a read-modify-write sequence for partial writes. The bridge sits between the core's instruction or data OBI port and one port of the dual-port RAM.

---
 rtl/cv32e41s_obi_ram_bridge.sv | 125 ++++++++++++
 tb/tb_cv32e41s_obi_ram_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_obi_ram_bridge.sv
// OBI-to-single-port-RAM bridge for the cv32e41s word-wide on-chip RAM.
// Partial writes become a read-modify-write because the RAM port has no byte enables.
module cv32e41s_obi_ram_bridge #(
    parameter int unsigned A_WID    = 32,
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             obi_req_i,
    output logic             obi_gnt_o,
    input  logic [A_WID-1:0] obi_addr_i,
    input  logic             obi_we_i,
    input  logic [3:0]       obi_be_i,
    input  logic [31:0]      obi_wdata_i,
    output logic             obi_rvalid_o,
    output logic [31:0]      obi_rdata_o,
    output logic             obi_err_o,
    output logic             ram_en_o,
    output logic             ram_we_o,
    output logic [A_WID-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESP  = 2'd1;
    localparam logic [1:0] S_MERGE = 2'd2;

    localparam logic [A_WID-3:0] MEM_WORDS = (A_WID-2)'(MEM_SIZE);
    localparam logic [A_WID-1:0] LSB_MASK  = A_WID'(3);

    logic [1:0]       state_q, state_d;
    logic             err_q, err_d;
    logic             rd_q, rd_d;
    logic [A_WID-1:0] addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [A_WID-1:0] addr_aligned;
    logic             out_of_range;
    logic [31:0]      merged;

    assign addr_aligned = obi_addr_i & ~LSB_MASK;
    assign out_of_range = obi_addr_i[A_WID-1:2] >= MEM_WORDS;

    // Grant is held low during reset even though the state already reads IDLE.
    assign obi_gnt_o    = obi_req_i && rst_ni && (state_q != S_MERGE);
    assign obi_rvalid_o = (state_q == S_RESP);
    assign obi_err_o    = (state_q == S_RESP) && err_q;
    assign obi_rdata_o  = ((state_q == S_RESP) && rd_q) ? ram_rdata_i : '0;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_rdata_i[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        if (state_q == S_MERGE) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = addr_q;
            ram_wdata_o = merged;
            state_d     = S_RESP;
            err_d       = 1'b0;
            rd_d        = 1'b0;
        end else if (obi_gnt_o) begin
            state_d = S_RESP;
            err_d   = 1'b0;
            rd_d    = 1'b0;
            if (out_of_range) begin
                err_d = 1'b1;
            end else if (!obi_we_i) begin
                ram_en_o   = 1'b1;
                ram_addr_o = addr_aligned;
                rd_d       = 1'b1;
            end else if (obi_be_i == 4'hF) begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = addr_aligned;
                ram_wdata_o = obi_wdata_i;
            end else if (obi_be_i != 4'h0) begin
                // Fetch the old word now; the merged write goes out from MERGE.
                ram_en_o   = 1'b1;
                ram_addr_o = addr_aligned;
                addr_d     = addr_aligned;
                be_d       = obi_be_i;
                wdata_d    = obi_wdata_i;
                state_d    = S_MERGE;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_cv32e41s_obi_ram_bridge.sv
// Directed bench for cv32e41s_obi_ram_bridge with a behavioural read-first RAM behind it.
module tb_cv32e41s_obi_ram_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        obi_req_i = 1'b0;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i = '0;
    logic        obi_we_i = 1'b0;
    logic [3:0]  obi_be_i = '0;
    logic [31:0] obi_wdata_i = '0;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;

    logic [31:0] mem [1024];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    cv32e41s_obi_ram_bridge #(.A_WID(32), .MEM_SIZE(1024)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    always @(posedge clk_i) begin
        if (ram_en_o) begin
            ram_rdata_i <= mem[ram_addr_o[11:2]];
            if (ram_we_o) mem[ram_addr_o[11:2]] <= ram_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        @(posedge clk_i);
        #1;
        obi_req_i   = req;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wdata;
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    logic [31:0] stream_exp [8];

    initial begin
        mem[0]  <= 32'h0BAD_F00D;
        mem[4]  <= 32'hDEAD_BEEF;
        mem[12] <= 32'hAABB_CCDD;
        mem[16] <= 32'h5566_7788;

        // Reset with a request pending: grant must stay low.
        obi_req_i = 1'b1;
        #12;
        chk("rst_gnt",    {31'b0, obi_gnt_o},    32'h0);
        chk("rst_rvalid", {31'b0, obi_rvalid_o}, 32'h0);
        chk("rst_err",    {31'b0, obi_err_o},    32'h0);
        chk("rst_rdata",  obi_rdata_o,           32'h0);
        chk("rst_ram_en", {31'b0, ram_en_o},     32'h0);
        chk("rst_ram_we", {31'b0, ram_we_o},     32'h0);
        obi_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Single read of a preloaded word.
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        chk("rd_gnt",    {31'b0, obi_gnt_o}, 32'h1);
        chk("rd_en",     {31'b0, ram_en_o},  32'h1);
        chk("rd_we",     {31'b0, ram_we_o},  32'h0);
        chk("rd_addr",   ram_addr_o,         32'h10);
        chk("rd_novld",  {31'b0, obi_rvalid_o}, 32'h0);
        idle();
        chk("rd_rvalid", {31'b0, obi_rvalid_o}, 32'h1);
        chk("rd_rdata",  obi_rdata_o,           32'hDEAD_BEEF);
        chk("rd_err",    {31'b0, obi_err_o},    32'h0);

        // Full write followed by a read accepted during the write's response.
        drive(1'b1, 1'b1, 32'h20, 4'hF, 32'h1234_5678);
        chk("fw_gnt",   {31'b0, obi_gnt_o}, 32'h1);
        chk("fw_we",    {31'b0, ram_we_o},  32'h1);
        chk("fw_wdata", ram_wdata_o,        32'h1234_5678);
        drive(1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        chk("fw_gnt2",   {31'b0, obi_gnt_o},    32'h1);
        chk("fw_rvalid", {31'b0, obi_rvalid_o}, 32'h1);
        chk("fw_rdata0", obi_rdata_o,           32'h0);
        chk("fw_rd_we",  {31'b0, ram_we_o},     32'h0);
        idle();
        chk("fw_rvalid2", {31'b0, obi_rvalid_o}, 32'h1);
        chk("fw_rdback",  obi_rdata_o,           32'h1234_5678);

        // Partial write be=0101 then read back the merged word.
        drive(1'b1, 1'b1, 32'h32, 4'b0101, 32'h1122_3344);
        chk("pw_gnt", {31'b0, obi_gnt_o}, 32'h1);
        chk("pw_en",  {31'b0, ram_en_o},  32'h1);
        chk("pw_we",  {31'b0, ram_we_o},  32'h0);
        chk("pw_addr", ram_addr_o,        32'h30);
        drive(1'b1, 1'b1, 32'h32, 4'b0101, 32'h1122_3344);
        chk("pw_m_gnt",   {31'b0, obi_gnt_o},    32'h0);
        chk("pw_m_we",    {31'b0, ram_we_o},     32'h1);
        chk("pw_m_addr",  ram_addr_o,            32'h30);
        chk("pw_m_wdata", ram_wdata_o,           32'hAA22_CC44);
        chk("pw_m_vld",   {31'b0, obi_rvalid_o}, 32'h0);
        drive(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        chk("pw_rvalid", {31'b0, obi_rvalid_o}, 32'h1);
        chk("pw_err",    {31'b0, obi_err_o},    32'h0);
        chk("pw_rd_gnt", {31'b0, obi_gnt_o},    32'h1);
        idle();
        chk("pw_rdback", obi_rdata_o, 32'hAA22_CC44);

        // Out-of-range read, then be=0 write to word 0.
        drive(1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
        chk("oor_gnt", {31'b0, obi_gnt_o}, 32'h1);
        chk("oor_en",  {31'b0, ram_en_o},  32'h0);
        drive(1'b1, 1'b1, 32'h0, 4'h0, 32'hFFFF_FFFF);
        chk("oor_rvalid", {31'b0, obi_rvalid_o}, 32'h1);
        chk("oor_err",    {31'b0, obi_err_o},    32'h1);
        chk("oor_rdata",  obi_rdata_o,           32'h0);
        chk("be0_gnt",    {31'b0, obi_gnt_o},    32'h1);
        chk("be0_en",     {31'b0, ram_en_o},     32'h0);
        idle();
        chk("be0_rvalid", {31'b0, obi_rvalid_o}, 32'h1);
        chk("be0_err",    {31'b0, obi_err_o},    32'h0);

        // Back-to-back stream of eight reads; word 0 must still hold its preload.
        stream_exp[0] = 32'h0BAD_F00D;
        for (int i = 1; i < 8; i++) begin
            stream_exp[i] = 32'hC0DE_0000 | 32'(i);
            mem[i] <= stream_exp[i];
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                drive(1'b1, 1'b0, 32'(4 * i), 4'hF, 32'h0);
                chk($sformatf("st_gnt%0d", i), {31'b0, obi_gnt_o}, 32'h1);
            end else begin
                idle();
            end
            if (i > 0) begin
                chk($sformatf("st_vld%0d", i - 1), {31'b0, obi_rvalid_o}, 32'h1);
                chk($sformatf("st_dat%0d", i - 1), obi_rdata_o, stream_exp[i - 1]);
            end
        end
        idle();
        chk("st_done", {31'b0, obi_rvalid_o}, 32'h0);

        // Reset pulsed while in MERGE: the merged write must never reach the RAM.
        drive(1'b1, 1'b1, 32'h40, 4'b0010, 32'h0000_0000);
        chk("rm_gnt", {31'b0, obi_gnt_o}, 32'h1);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("rm_en",     {31'b0, ram_en_o},     32'h0);
        chk("rm_we",     {31'b0, ram_we_o},     32'h0);
        chk("rm_rvalid", {31'b0, obi_rvalid_o}, 32'h0);
        chk("rm_gnt0",   {31'b0, obi_gnt_o},    32'h0);
        chk("rm_err",    {31'b0, obi_err_o},    32'h0);
        obi_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rm_novld", {31'b0, obi_rvalid_o}, 32'h0);
        drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        chk("rm_rd_gnt", {31'b0, obi_gnt_o}, 32'h1);
        idle();
        chk("rm_rd_vld", {31'b0, obi_rvalid_o}, 32'h1);
        chk("rm_rdback", obi_rdata_o,           32'h5566_7788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
